// File: rtl/writeback_unit_if.sv
// MEM/WB to writeback bundle, plus the decode read ports and the fetch/flags outputs.
// The master side drives the pipeline inputs; the slave side is the writeback unit.
interface writeback_unit_if #(
    parameter int DATA_W = 32
);
    logic              RegWriteW;
    logic              MemtoRegW;
    logic              FlagsWriteW;
    logic [DATA_W-1:0] ReadDataW;
    logic [DATA_W-1:0] ALUOutW;
    logic [3:0]        WA3W;
    logic [3:0]        ALUFlagsW;
    logic [3:0]        RA1D;
    logic [3:0]        RA2D;
    logic [DATA_W-1:0] PCPlus8D;
    logic [DATA_W-1:0] ResultW;
    logic [DATA_W-1:0] RD1D;
    logic [DATA_W-1:0] RD2D;
    logic [3:0]        FlagsQ;
    logic              PCWriteW;
    logic [31:0]       RetireCnt;

    modport master (
        output RegWriteW, MemtoRegW, FlagsWriteW,
        output ReadDataW, ALUOutW, WA3W, ALUFlagsW,
        output RA1D, RA2D, PCPlus8D,
        input  ResultW, RD1D, RD2D, FlagsQ, PCWriteW, RetireCnt
    );

    modport slave (
        input  RegWriteW, MemtoRegW, FlagsWriteW,
        input  ReadDataW, ALUOutW, WA3W, ALUFlagsW,
        input  RA1D, RA2D, PCPlus8D,
        output ResultW, RD1D, RD2D, FlagsQ, PCWriteW, RetireCnt
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: result select, R0-R14 register file with write-through reads, NZCV flags.
// Defining WB_RETIRE_CNT_EN adds a 32-bit commit counter on RetireCnt.
module writeback_unit #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 15
) (
    input logic             clk,
    input logic             rst,
    writeback_unit_if.slave wb
);
    localparam logic [3:0] PC_IDX = 4'd15;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [3:0]        flags;
    logic              reg_we;

    // R15 is the PC: never stored, reported to fetch instead
    always_comb begin
        result = wb.MemtoRegW ? wb.ReadDataW : wb.ALUOutW;
        reg_we = wb.RegWriteW && (wb.WA3W != PC_IDX);
    end

    assign wb.ResultW  = result;
    assign wb.PCWriteW = wb.RegWriteW && (wb.WA3W == PC_IDX);

    always_comb begin
        rd1 = '0;
        unique case (1'b1)
            wb.RA1D == PC_IDX:            rd1 = wb.PCPlus8D;
            reg_we && wb.WA3W == wb.RA1D: rd1 = result;
            default:                      rd1 = regs[wb.RA1D];
        endcase
    end

    always_comb begin
        rd2 = '0;
        unique case (1'b1)
            wb.RA2D == PC_IDX:            rd2 = wb.PCPlus8D;
            reg_we && wb.WA3W == wb.RA2D: rd2 = result;
            default:                      rd2 = regs[wb.RA2D];
        endcase
    end

    assign wb.RD1D = rd1;
    assign wb.RD2D = rd2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[wb.WA3W] <= result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags <= 4'b0000;
        end else if (wb.FlagsWriteW) begin
            flags <= wb.ALUFlagsW;
        end
    end

    assign wb.FlagsQ = flags;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt <= '0;
        end else if (wb.RegWriteW || wb.FlagsWriteW) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign wb.RetireCnt = retire_cnt;
`else
    assign wb.RetireCnt = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expectations queued at drive time, drained per cycle.
// Inputs change on the falling edge, outputs are sampled 1 time unit later.
module tb_writeback_unit;
    localparam int DW = 32;
`ifdef WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef enum int {K_RD1, K_RD2, K_RES, K_FLG, K_PCW, K_CNT} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        logic [31:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_unit_if #(.DATA_W(DW)) wb ();

    writeback_unit #(.DATA_W(DW), .NREGS(15)) dut (
        .clk(clk),
        .rst(rst),
        .wb (wb)
    );

    sb_t         sb_q[$];
    logic [31:0] m_regs [15];
    logic [3:0]  m_flags;
    logic [31:0] m_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input kind_t k);
        case (k)
            K_RD1:   return wb.RD1D;
            K_RD2:   return wb.RD2D;
            K_RES:   return wb.ResultW;
            K_FLG:   return {28'd0, wb.FlagsQ};
            K_PCW:   return {31'd0, wb.PCWriteW};
            default: return wb.RetireCnt;
        endcase
    endfunction

    task automatic push(input string tag, input kind_t k, input logic [31:0] e);
        sb_t s;
        s.tag  = tag;
        s.kind = k;
        s.exp  = e;
        sb_q.push_back(s);
    endtask

    task automatic drain();
        sb_t s;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            check(s.tag, observe(s.kind), s.exp);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [3:0] ra, input logic [31:0] res);
        if (ra == 4'd15) return wb.PCPlus8D;
        if (wb.RegWriteW && wb.WA3W == ra) return res;
        return m_regs[ra];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 15; i++) m_regs[i] = '0;
        m_flags = 4'b0000;
        m_cnt   = '0;
    endtask

    task automatic drv(input logic rw, input logic m2r, input logic fw,
                       input logic [31:0] rd, input logic [31:0] alu,
                       input logic [3:0] wa, input logic [3:0] fl,
                       input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic [31:0] pc);
        wb.RegWriteW   = rw;
        wb.MemtoRegW   = m2r;
        wb.FlagsWriteW = fw;
        wb.ReadDataW   = rd;
        wb.ALUOutW     = alu;
        wb.WA3W        = wa;
        wb.ALUFlagsW   = fl;
        wb.RA1D        = ra1;
        wb.RA2D        = ra2;
        wb.PCPlus8D    = pc;
    endtask

    // Called just after a falling edge; checks, crosses the rising edge, returns at the next falling edge
    task automatic step(input string tag);
        logic [31:0] res;
        #1;
        res = wb.MemtoRegW ? wb.ReadDataW : wb.ALUOutW;
        push({tag, ":rd1"}, K_RD1, m_rd(wb.RA1D, res));
        push({tag, ":rd2"}, K_RD2, m_rd(wb.RA2D, res));
        push({tag, ":res"}, K_RES, res);
        push({tag, ":pcw"}, K_PCW, {31'd0, wb.RegWriteW && wb.WA3W == 4'd15});
        push({tag, ":flg"}, K_FLG, {28'd0, m_flags});
        push({tag, ":cnt"}, K_CNT, m_cnt);
        drain();
        @(posedge clk);
        if (rst) begin
            if (wb.RegWriteW && wb.WA3W != 4'd15) m_regs[wb.WA3W] = res;
            if (wb.FlagsWriteW) m_flags = wb.ALUFlagsW;
            if (CNT_EN && (wb.RegWriteW || wb.FlagsWriteW)) m_cnt = m_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic reset_mid(input string tag);
        drv(0, 0, 0, 0, 0, 0, 0, 4'd3, 4'd7, 32'h208);
        #2 rst = 1'b0;
        m_clear();
        step(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_clear();
        #1 rst = 1'b0;
        @(negedge clk);
        step("por");
        rst = 1'b1;

        drv(1, 1, 0, 32'hDEADBEEF, 32'h1, 4'd3, 0, 4'd3, 4'd3, 32'h208);
        step("ld_r3");
        drv(1, 0, 0, 32'hDEADBEEF, 32'h1, 4'd4, 0, 4'd3, 4'd4, 32'h208);
        step("alu_r4");
        drv(0, 0, 0, 0, 0, 0, 0, 4'd4, 4'd3, 32'h208);
        step("rd_back");
        check("r3_load", wb.RD2D, 32'hDEADBEEF);
        check("r4_alu", wb.RD1D, 32'h1);

        drv(1, 0, 0, 0, 32'hAAAA0000, 4'd7, 0, 4'd7, 4'd7, 32'h208);
        step("r7_old");
        drv(0, 0, 0, 0, 32'h12345678, 4'd7, 0, 4'd7, 4'd7, 32'h208);
        step("r7_nowr");
        drv(1, 0, 0, 0, 32'h12345678, 4'd7, 0, 4'd7, 4'd7, 32'h208);
        step("r7_byp");
        drv(0, 0, 0, 0, 0, 0, 0, 4'd7, 4'd7, 32'h208);
        step("r7_st");

        drv(1, 0, 0, 0, 32'h100, 4'd15, 0, 4'd15, 4'd3, 32'h208);
        step("r15");
        for (int i = 0; i < 15; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 4'(i), 4'(14 - i), 32'h208);
            step("regs");
        end

        drv(0, 0, 1, 0, 0, 0, 4'b1010, 0, 0, 32'h208);
        step("flg_set");
        drv(0, 0, 0, 0, 0, 0, 4'b0101, 0, 0, 32'h208);
        step("flg_hold");
        step("flg_hold2");

        drv(1, 0, 1, 0, 32'h77, 4'd9, 4'b0110, 4'd9, 4'd15, 32'h300);
        step("both");
        drv(0, 0, 0, 0, 0, 0, 0, 4'd9, 4'd9, 32'h300);
        step("both_st");

        for (int i = 0; i < 60; i++) begin
            drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom, $urandom,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
            step("rand");
        end

        reset_mid("rst_mid");
        drv(1, 0, 1, 0, 32'h55, 4'd5, 4'b1111, 4'd5, 4'd5, 32'h208);
        step("rst_hold");
        rst = 1'b1;
        step("rst_rel");
        drv(0, 0, 0, 0, 0, 0, 0, 4'd5, 4'd5, 32'h208);
        step("after_rel");

        reset_mid("cnt_rst");
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 1)
                drv(0, 0, 0, 0, 32'hF0 + 32'(i), 4'd2, 0, 4'd2, 4'd1, 32'h208);
            else
                drv(1, 0, 1, 0, 32'hF0 + 32'(i), 4'd2, 4'(i), 4'd2, 4'd1, 32'h208);
            step("cnt_run");
        end
        #1;
        push("cnt5", K_CNT, CNT_EN ? 32'd5 : 32'd0);
        drain();
`ifdef WB_RETIRE_CNT_EN
        force dut.retire_cnt = 32'hFFFFFFFF;
        #1 release dut.retire_cnt;
        m_cnt = 32'hFFFFFFFF;
        drv(1, 0, 0, 0, 32'h9, 4'd1, 0, 4'd1, 4'd1, 32'h208);
        step("cnt_wrap");
        drv(0, 0, 0, 0, 0, 0, 0, 4'd1, 4'd1, 32'h208);
        step("cnt_zero");
        #1;
        push("cnt_wrapped", K_CNT, 32'd0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
